stack_mem: RTL and testbench
============================

// Module: stack_mem
// PURPOSE
//  Word-addressed program/data memory serving the stack CPU's fetch/data bus (CPU drives a 15-bit
//  word address and takes 16-bit words back).
//  Includes a byte-stream program loader so a host can fill memory after reset before the CPU runs.
//  Sits between the CPU address/data port and the board-level loader.
// PARAMETERS
//  DEPTH_LOG2  10      log2 of word count; array holds 2**DEPTH_LOG2 16-bit words
//  ADDR_W      15      CPU word-address width
//  DATA_W      16      word width, fixed at 16
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  address     in   ADDR_W  CPU word address
//  rd_en       in   1       CPU read request, sampled each clk
//  wr_en       in   1       CPU write request; wr_en wins over rd_en when both are high
//  wr_data     in   16      CPU write data
//  byte_en     in   2       write lane enables; [1]=bits 15:8, [0]=bits 7:0
//  data_out    out  16      read data, registered
//  rd_valid    out  1       1-cycle pulse, data_out valid
//  busy        out  1       loader owns the array; CPU requests are ignored
//  load_valid  in   1       loader byte strobe
//  load_byte   in   8       loader byte
//  load_last   in   1       qualifies the final byte of the image
//  load_ready  out  1       loader byte accepted when load_valid & load_ready
//  load_done   out  1       1-cycle pulse once the final word is written
// BEHAVIOUR
//  Reset:
//   - data_out=0, rd_valid=0, busy=0, load_ready=1, load_done=0.
//   - Load pointer = 0, FSM = IDLE.
//   - Array contents are NOT reset.
//  Address mapping: only address[DEPTH_LOG2-1:0] is decoded; higher addresses alias modulo depth.
//  CPU read (IDLE, rd_en & ~wr_en):
//   - data_out = mem[addr] on the next edge, with rd_valid high for exactly that cycle.
//   - data_out holds its value until the next read completes.
//  CPU write (IDLE, wr_en):
//   - Lanes selected by byte_en are written at the edge.
//   - No rd_valid is produced.
//   - Read after write to the same address returns the new data.
//  FSM states and transitions:
//   - IDLE -> LOAD_LO: load_valid in IDLE. busy asserts on that same edge; the byte is latched as the
//     high byte (opcode byte first, matching the CPU's hi-then-lo byte execution).
//   - LOAD_LO -> LOAD_HI: next accepted byte is the low byte. Write {hi,lo} at ptr, then ptr++.
//   - LOAD_HI -> LOAD_LO: next accepted byte is a high byte (latched).
//   - load_last on a low byte: write the word, go to DONE.
//   - load_last on a high byte: write {hi,8'h00} (low slot padded with NOP), go to DONE.
//   - DONE: load_done=1 for one cycle, ptr=0, busy=0, -> IDLE.
//  busy is high in LOAD_LO, LOAD_HI and DONE.
//  load_ready is 1 in IDLE/LOAD_LO/LOAD_HI and 0 in DONE; a byte offered in DONE is held off.
//  Pointer wraps from 2**DEPTH_LOG2-1 to 0 silently; an oversize image overwrites the start.
//  Simultaneous events:
//   - CPU rd_en/wr_en in the same cycle as a load_valid that starts a load: the CPU access is dropped.
//   - The loader always has priority; rd_valid stays 0.
//  Reset mid-load: partial high byte discarded, ptr=0, FSM=IDLE, no load_done pulse. Words already
//  written stay in the array.
//  load_valid with load_ready=0 has no effect.
// STRUCTURE
//  - defines.vh gains: MEM_DATA_W, loader state encodings (`LD_IDLE, `LD_LO, `LD_HI, `LD_DONE),
//    NOP byte constant 8'h00.
//  - Sub-module spram_be (single-port RAM, 2 byte lanes, registered read) holds the array.
//  - stack_mem muxes the loader vs CPU onto its port and owns the FSM and pointer.
// TESTING
//  1. Reset, then 4 bytes A1 B2 C3 D4 with last on D4 -> mem[0]=A1B2, mem[1]=C3D4, one load_done,
//     busy falls.
//  2. 3 bytes 11 22 33, last on 33 -> mem[1]=3300; CPU rd addr 1 -> rd_valid next cycle,
//     data_out=3300.
//  3. CPU wr addr 5 data BEEF byte_en=10 over 1234 -> read gives BE34. Then rd addr 5+1024 -> BE34
//     (aliasing).
//  4. rd_en asserted on the same cycle load_valid starts a load -> no rd_valid; busy=1 next cycle.
//  5. rst_n low after a single high byte 7F -> busy=0, load_ready=1; the next load writes from
//     address 0 with no 7F residue.
//  6. 2050-byte image (DEPTH_LOG2=10) -> ptr wraps; mem[0] holds the word from bytes 2048-2049;
//     single load_done.

Source files
------------

// File: rtl/stack_mem_pkg.sv
// Shared constants and loader state type for the stack CPU memory block.
package stack_mem_pkg;

    localparam int         MEM_DATA_W = 16;
    localparam logic [7:0] NOP_BYTE   = 8'h00;

    // LD_LO waits for the low byte of a word, LD_HI for the next high byte.
    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LO,
        LD_HI,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/stack_mem_if.sv
// CPU word bus plus byte-stream loader port of the stack CPU memory.
interface stack_mem_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        byte_en;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;
    logic              load_done;

    modport master (
        output address, rd_en, wr_en, wr_data, byte_en,
        output load_valid, load_byte, load_last,
        input  data_out, rd_valid, busy, load_ready, load_done
    );

    modport slave (
        input  address, rd_en, wr_en, wr_data, byte_en,
        input  load_valid, load_byte, load_last,
        output data_out, rd_valid, busy, load_ready, load_done
    );

endinterface

// File: rtl/stack_mem_spram_be.sv
// Single-port RAM with two byte-lane write enables and a registered read port.
module spram_be
    import stack_mem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [AW-1:0]         addr,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem_q [0:(1<<AW)-1];
    logic [MEM_DATA_W-1:0] rdata_d;
    logic [MEM_DATA_W-1:0] rdata_q;

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
            if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stack_mem.sv
// Stack CPU program/data memory: arbitrates the CPU bus against a byte-stream image loader.
module stack_mem
    import stack_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    stack_mem_if.slave bus
);

    ld_state_t             state_d, state_q;
    logic [DEPTH_LOG2-1:0] ptr_d, ptr_q;
    logic [7:0]            hi_d, hi_q;
    logic                  rd_valid_d, rd_valid_q;

    logic                  ram_en;
    logic                  ram_we;
    logic [1:0]            ram_be;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  cpu_rd;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.address[ADDR_W-1:DEPTH_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            ptr_q      <= '0;
            hi_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hi_q       <= hi_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        case (state_q)
            LD_IDLE: begin
                if (bus.load_valid) begin
                    hi_d    = bus.load_byte;
                    state_d = bus.load_last ? LD_DONE : LD_LO;
                end
            end
            LD_LO: begin
                if (bus.load_valid) begin
                    ptr_d   = ptr_q + DEPTH_LOG2'(1);
                    state_d = bus.load_last ? LD_DONE : LD_HI;
                end
            end
            LD_HI: begin
                if (bus.load_valid) begin
                    hi_d    = bus.load_byte;
                    state_d = bus.load_last ? LD_DONE : LD_LO;
                end
            end
            LD_DONE: begin
                ptr_d   = '0;
                state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // A final lone high byte is written immediately with a NOP low slot.
    always_comb begin
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_be         = '0;
        ram_addr       = bus.address[DEPTH_LOG2-1:0];
        ram_wdata      = bus.wr_data;
        cpu_rd         = 1'b0;
        bus.busy       = (state_q != LD_IDLE);
        bus.load_ready = (state_q != LD_DONE);
        bus.load_done  = (state_q == LD_DONE);
        case (state_q)
            LD_IDLE: begin
                if (bus.load_valid) begin
                    if (bus.load_last) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_be    = '1;
                        ram_addr  = ptr_q;
                        ram_wdata = {bus.load_byte, NOP_BYTE};
                    end
                end else if (bus.wr_en) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    ram_be = bus.byte_en;
                end else if (bus.rd_en) begin
                    ram_en = 1'b1;
                    cpu_rd = 1'b1;
                end
            end
            LD_LO: begin
                if (bus.load_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_addr  = ptr_q;
                    ram_wdata = {hi_q, bus.load_byte};
                end
            end
            LD_HI: begin
                if (bus.load_valid && bus.load_last) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_addr  = ptr_q;
                    ram_wdata = {bus.load_byte, NOP_BYTE};
                end
            end
            default: ;
        endcase
    end

    assign rd_valid_d   = cpu_rd;
    assign bus.rd_valid = rd_valid_q;
    assign bus.data_out = ram_rdata;

    spram_be #(
        .AW(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stack_mem.sv
// Directed bench for stack_mem: loader images, CPU reads/writes, priority, reset and wrap.
module tb_stack_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  img [0:2049];

    always #5 clk = ~clk;

    stack_mem_if #(.ADDR_W(15), .DATA_W(16)) bus();

    stack_mem #(
        .DEPTH_LOG2(10),
        .ADDR_W    (15),
        .DATA_W    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.load_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        tick;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.address = a;
        bus.wr_data = d;
        bus.byte_en = be;
        bus.wr_en   = 1'b1;
        tick;
        bus.wr_en = 1'b0;
        check("wr no rd_valid", bus.rd_valid, 0);
    endtask

    task automatic cpu_read(input logic [14:0] a, input logic [15:0] exp, input string tag);
        logic got;
        got = 1'b0;
        exp_q.push_back(exp);
        bus.address = a;
        bus.rd_en   = 1'b1;
        tick;
        bus.rd_en = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (bus.rd_valid === 1'b1) got = 1'b1;
            else tick;
        end
        check({tag, " rd_valid"}, got, 1);
        if (got) check(tag, bus.data_out, exp_q.pop_front());
        else     void'(exp_q.pop_front());
        tick;
        check({tag, " pulse"}, bus.rd_valid, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.address    = '0;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.byte_en    = '0;
        bus.load_valid = 1'b0;
        bus.load_byte  = '0;
        bus.load_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst data_out",   bus.data_out,   0);
        check("rst rd_valid",   bus.rd_valid,   0);
        check("rst busy",       bus.busy,       0);
        check("rst load_ready", bus.load_ready, 1);
        check("rst load_done",  bus.load_done,  0);
        rst_n = 1'b1;
        tick;

        // 1: four-byte image, then a byte offered during DONE is held off
        send(8'hA1, 1'b0);
        check("t1 busy",  bus.busy,       1);
        check("t1 ready", bus.load_ready, 1);
        send(8'hB2, 1'b0);
        send(8'hC3, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'hD4;
        bus.load_last  = 1'b1;
        tick;
        check("t1 load_done", bus.load_done,  1);
        check("t1 done ready", bus.load_ready, 0);
        check("t1 done busy", bus.busy,       1);
        bus.load_byte = 8'hEE;
        bus.load_last = 1'b0;
        tick;
        bus.load_valid = 1'b0;
        check("t1 done pulse", bus.load_done, 0);
        check("t1 busy falls", bus.busy,      0);
        check("t1 done count", done_cnt,      1);
        cpu_read(15'd0, 16'hA1B2, "t1 mem0");
        cpu_read(15'd1, 16'hC3D4, "t1 mem1");

        // 2: odd-length image pads the last word with NOP
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        check("t2 load_done", bus.load_done, 1);
        tick;
        check("t2 busy", bus.busy, 0);
        check("t2 done count", done_cnt, 2);
        cpu_read(15'd1, 16'h3300, "t2 mem1");
        cpu_read(15'd0, 16'h1122, "t2 mem0");

        // 3: byte-lane write, data_out hold, aliasing
        cpu_write(15'd5, 16'h1234, 2'b11);
        cpu_write(15'd5, 16'hBEEF, 2'b10);
        check("t3 data_out hold", bus.data_out, 16'h1122);
        cpu_read(15'd5, 16'hBE34, "t3 mem5");
        cpu_read(15'd5 + 15'd1024, 16'hBE34, "t3 alias");

        // 4: loader start wins over a CPU read; CPU write while busy is dropped
        bus.address    = 15'd1;
        bus.rd_en      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'h55;
        tick;
        bus.rd_en      = 1'b0;
        bus.load_valid = 1'b0;
        check("t4 no rd_valid", bus.rd_valid, 0);
        check("t4 busy", bus.busy, 1);
        bus.wr_data = 16'hFFFF;
        bus.byte_en = 2'b11;
        bus.wr_en   = 1'b1;
        tick;
        bus.wr_en = 1'b0;
        check("t4 still busy", bus.busy, 1);
        send(8'h66, 1'b1);
        tick;
        cpu_read(15'd0, 16'h5566, "t4 mem0");
        cpu_read(15'd1, 16'h3300, "t4 mem1 untouched");
        check("t4 done count", done_cnt, 3);

        // 5: reset mid-load discards the partial high byte
        send(8'h7F, 1'b0);
        check("t5 busy before rst", bus.busy, 1);
        rst_n = 1'b0;
        #2;
        check("t5 rst busy",       bus.busy,       0);
        check("t5 rst load_ready", bus.load_ready, 1);
        check("t5 rst data_out",   bus.data_out,   0);
        #1 rst_n = 1'b1;
        tick;
        check("t5 no done pulse", done_cnt, 3);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        tick;
        cpu_read(15'd0, 16'h0102, "t5 mem0");
        cpu_read(15'd1, 16'h3300, "t5 mem1");
        check("t5 done count", done_cnt, 4);

        // 6: 2050-byte image wraps the pointer
        for (int i = 0; i < 2050; i++) img[i] = 8'(i * 37 + (i >> 8) + 3);
        for (int i = 0; i < 2050; i++) send(img[i], (i == 2049));
        check("t6 load_done", bus.load_done, 1);
        tick;
        check("t6 busy", bus.busy, 0);
        check("t6 done count", done_cnt, 5);
        cpu_read(15'd0,    {img[2048], img[2049]}, "t6 mem0 wrapped");
        cpu_read(15'd1,    {img[2],    img[3]},    "t6 mem1");
        cpu_read(15'd1023, {img[2046], img[2047]}, "t6 mem1023");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
